// File: rtl/vend_pkg.sv
// Shared types and default constants for the vend actuator sequencer.
package vend_pkg;

  localparam int unsigned CW            = 4;
  localparam int unsigned MOTOR_TIMEOUT = 15;
  localparam int unsigned EJECT_GAP     = 2;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StMotor = 3'd1,
    StEject = 3'd2,
    StGap   = 3'd3,
    StDone  = 3'd4,
    StFault = 3'd5
  } vend_state_e;

endpackage

// File: rtl/vend_timer.sv
// Clearable up-counter that flags when the count equals a fixed terminal value.
module vend_timer #(
  parameter int unsigned W  = 4,
  parameter int unsigned Tc = 14
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [W-1:0] TcVal = W'(Tc);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en && !tc) begin
      count_q <= count_q + W'(1);
    end
  end

  assign tc = (count_q == TcVal);

endmodule

// File: rtl/vend_sequencer.sv
// Drink motor / change ejector sequencer: one vend, motor run with timeout,
// then coin-by-coin change ejection with an enforced idle gap.
module vend_sequencer #(
  parameter int unsigned CW            = vend_pkg::CW,
  parameter int unsigned MOTOR_TIMEOUT = vend_pkg::MOTOR_TIMEOUT,
  parameter int unsigned EJECT_GAP     = vend_pkg::EJECT_GAP
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vend_req,
  input  logic [CW-1:0] change_amt,
  output logic          vend_accept,
  output logic          busy,
  output logic          motor_on,
  input  logic          motor_done,
  output logic          eject_coin,
  input  logic          eject_ack,
  output logic [CW-1:0] change_left,
  output logic          vend_done,
  output logic          fault,
  input  logic          fault_clr
);

  import vend_pkg::*;

  localparam int unsigned MtW = $clog2(MOTOR_TIMEOUT + 1);
  localparam int unsigned GtW = $clog2(EJECT_GAP + 1);

  vend_state_e   state_q, state_d;
  logic [CW-1:0] change_q, change_d;
  logic          accept_q, accept_d;
  logic          mt_clr, mt_en, mt_tc;
  logic          gt_clr, gt_en, gt_tc;

  vend_timer #(
    .W  (MtW),
    .Tc (MOTOR_TIMEOUT - 1)
  ) u_motor_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (mt_clr),
    .en    (mt_en),
    .tc    (mt_tc)
  );

  vend_timer #(
    .W  (GtW),
    .Tc (EJECT_GAP - 1)
  ) u_gap_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (gt_clr),
    .en    (gt_en),
    .tc    (gt_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      change_q <= '0;
      accept_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      change_q <= change_d;
      accept_q <= accept_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    change_d = change_q;
    accept_d = 1'b0;
    mt_clr   = 1'b0;
    mt_en    = 1'b0;
    gt_clr   = 1'b0;
    gt_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (vend_req) begin
          change_d = change_amt;
          mt_clr   = 1'b1;
          accept_d = 1'b1;
          state_d  = StMotor;
        end
      end
      StMotor: begin
        // Completion takes priority over a coincident timeout.
        if (motor_done) begin
          state_d = (change_q == '0) ? StDone : StEject;
        end else if (mt_tc) begin
          state_d = StFault;
        end else begin
          mt_en = 1'b1;
        end
      end
      StEject: begin
        if (change_q == '0) begin
          state_d = StDone;
        end else if (eject_ack) begin
          change_d = change_q - CW'(1);
          gt_clr   = 1'b1;
          state_d  = StGap;
        end
      end
      StGap: begin
        if (gt_tc) begin
          state_d = (change_q != '0) ? StEject : StDone;
        end else begin
          gt_en = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      StFault: begin
        if (fault_clr) begin
          change_d = '0;
          state_d  = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign vend_accept = accept_q;
  assign busy        = (state_q != StIdle);
  assign motor_on    = (state_q == StMotor);
  assign eject_coin  = (state_q == StEject);
  assign vend_done   = (state_q == StDone);
  assign fault       = (state_q == StFault);
  assign change_left = change_q;

endmodule
